// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage of the multicycle RV32I core.
// Holds the funct3 width/sign encodings, the access FSM state encoding and the
// pure helper functions that map an instruction's funct3 and byte offset onto
// byte enables, replicated store data and a legality verdict.
package mem_access_unit_pkg;

  // Load/store width codes as they appear in funct3
  localparam logic [2:0] FN3_B  = 3'b000;
  localparam logic [2:0] FN3_H  = 3'b001;
  localparam logic [2:0] FN3_W  = 3'b010;
  localparam logic [2:0] FN3_BU = 3'b100;
  localparam logic [2:0] FN3_HU = 3'b101;

  // Width of the wait-state timeout counter (covers 1..65535)
  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    MA_IDLE = 2'b00,
    MA_REQ  = 2'b01,
    MA_DONE = 2'b10,
    MA_HOLD = 2'b11
  } ma_state_e;

  // Byte-lane enables; funct3[1:0] carries the access size for both signed and unsigned codes
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so memory can pick any lane via byte enables
  function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] rep;
    case (f3[1:0])
      2'b00:   rep = {4{wd[7:0]}};
      2'b01:   rep = {2{wd[15:0]}};
      2'b10:   rep = wd;
      default: rep = 32'h0000_0000;
    endcase
    return rep;
  endfunction

  // Legal = exactly one of read/write, a supported funct3 for that direction, natural alignment
  function automatic logic request_legal(input logic rd, input logic wr,
                                         input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    if (rd && wr) begin
      ok = 1'b0;
    end else if (rd) begin
      ok = (f3 == FN3_B) || (f3 == FN3_H) || (f3 == FN3_W) ||
           (f3 == FN3_BU) || (f3 == FN3_HU);
    end else begin
      ok = (f3 == FN3_B) || (f3 == FN3_H) || (f3 == FN3_W);
    end
    if ((f3[1:0] == 2'b01) && off[0]) begin
      ok = 1'b0;
    end else if ((f3[1:0] == 2'b10) && (off != 2'b00)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks the addressed lane out of a memory read word and
// sign- or zero-extends it according to the load's funct3.
// Ports:
//   word   in  32  raw memory read word
//   offset in  2   byte offset of the access within the word
//   funct3 in  3   load width/sign code
//   value  out 32  extended load result
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [31:0] lane_s;

  // Shift the addressed byte/halfword down to bit 0
  assign lane_s = word >> {offset, 3'b000};

  // Extend the aligned lane to 32 bits
  always_comb begin
    value = 32'h0000_0000;
    case (funct3)
      FN3_B:   value = {{24{lane_s[7]}}, lane_s[7:0]};
      FN3_H:   value = {{16{lane_s[15]}}, lane_s[15:0]};
      FN3_W:   value = lane_s;
      FN3_BU:  value = {24'h00_0000, lane_s[7:0]};
      FN3_HU:  value = {16'h0000, lane_s[15:0]};
      default: value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage of the multicycle RV32I core.
// Accepts a load/store request from the control FSM, checks it, runs a
// req/ack handshake to data memory with a wait-state timeout, and returns
// extended load data plus done/err pulses. All outputs are registered.
// Ports:
//   CLK, RES          clock and synchronous active-high reset
//   memRead/memWrite  level request from the control FSM
//   funct3/addr/wdata instruction width code, byte address, store data
//   dmem_*            memory request channel (req held until ack)
//   busy              high while the request is outstanding
//   done/err          one-cycle completion pulse, err marks illegal/timeout
//   rdata             last completed load result
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam logic [TMR_W-1:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[TMR_W-1:0];

  ma_state_e        state_r, state_next_s;
  logic [TMR_W-1:0] cnt_r, cnt_next_s;
  logic [2:0]       f3_r, f3_next_s;
  logic [1:0]       off_r, off_next_s;
  logic             load_r, load_next_s;

  logic             req_next_s, we_next_s, busy_next_s, done_next_s, err_next_s;
  logic [31:0]      addr_next_s, wd_next_s, rdata_next_s;
  logic [3:0]       be_next_s;

  logic             legal_s;
  logic [31:0]      ext_s;

  assign legal_s = request_legal(memRead, memWrite, funct3, addr[1:0]);

  load_extend u_load_extend (
    .word   (dmem_rdata),
    .offset (off_r),
    .funct3 (f3_r),
    .value  (ext_s)
  );

  // Next-state and next-output logic; every output is held unless a transition updates it
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    f3_next_s    = f3_r;
    off_next_s   = off_r;
    load_next_s  = load_r;
    req_next_s   = dmem_req;
    we_next_s    = dmem_we;
    addr_next_s  = dmem_addr;
    be_next_s    = dmem_be;
    wd_next_s    = dmem_wdata;
    busy_next_s  = busy;
    done_next_s  = 1'b0;
    err_next_s   = 1'b0;
    rdata_next_s = rdata;

    case (state_r)
      MA_IDLE: begin
        if (memRead || memWrite) begin
          f3_next_s   = funct3;
          off_next_s  = addr[1:0];
          load_next_s = memRead & ~memWrite;
          cnt_next_s  = {TMR_W{1'b0}};
          if (legal_s) begin
            state_next_s = MA_REQ;
            req_next_s   = 1'b1;
            busy_next_s  = 1'b1;
            we_next_s    = memWrite;
            addr_next_s  = {addr[31:2], 2'b00};
            be_next_s    = byte_enable(funct3, addr[1:0]);
            wd_next_s    = store_replicate(funct3, wdata);
          end else begin
            // Rejected request: report immediately, memory is never touched
            state_next_s = MA_DONE;
            done_next_s  = 1'b1;
            err_next_s   = 1'b1;
          end
        end else begin
          state_next_s = MA_IDLE;
        end
      end

      MA_REQ: begin
        // Ack is tested first so a same-cycle ack beats the timeout
        if (dmem_ack) begin
          state_next_s = MA_DONE;
          done_next_s  = 1'b1;
          if (load_r) begin
            rdata_next_s = ext_s;
          end else begin
            rdata_next_s = rdata;
          end
        end else if ((cnt_r + {{(TMR_W-1){1'b0}}, 1'b1}) == TIMEOUT_LIMIT) begin
          state_next_s = MA_DONE;
          done_next_s  = 1'b1;
          err_next_s   = 1'b1;
          cnt_next_s   = cnt_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_next_s = cnt_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end
        // Leaving REQ clears the request channel
        if (state_next_s == MA_DONE) begin
          req_next_s  = 1'b0;
          busy_next_s = 1'b0;
          we_next_s   = 1'b0;
          addr_next_s = 32'h0000_0000;
          be_next_s   = 4'b0000;
          wd_next_s   = 32'h0000_0000;
        end else begin
          req_next_s  = 1'b1;
          busy_next_s = 1'b1;
        end
      end

      MA_DONE: begin
        // A still-asserted request is the same instruction; park until it drops
        if (memRead || memWrite) begin
          state_next_s = MA_HOLD;
        end else begin
          state_next_s = MA_IDLE;
        end
      end

      MA_HOLD: begin
        if (!(memRead || memWrite)) begin
          state_next_s = MA_IDLE;
        end else begin
          state_next_s = MA_HOLD;
        end
      end

      default: begin
        state_next_s = MA_IDLE;
        req_next_s   = 1'b0;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_r    <= MA_IDLE;
      cnt_r      <= {TMR_W{1'b0}};
      f3_r       <= 3'b000;
      off_r      <= 2'b00;
      load_r     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h0000_0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0000_0000;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      f3_r       <= f3_next_s;
      off_r      <= off_next_s;
      load_r     <= load_next_s;
      dmem_req   <= req_next_s;
      dmem_we    <= we_next_s;
      dmem_addr  <= addr_next_s;
      dmem_be    <= be_next_s;
      dmem_wdata <= wd_next_s;
      busy       <= busy_next_s;
      done       <= done_next_s;
      err        <= err_next_s;
      rdata      <= rdata_next_s;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of control_unit in the multicycle RV32I core.
- Consumes memRead/memWrite asserted in MEM_ACCESS, plus ALU address, rs2 data and funct3.
- Runs a req/ack transaction to data memory, generating byte enables and store-data replication, then extracting, sign-extending or zero-extending load data.
- Reports busy/done/err so the state machine can stall on wait states.

Parameters:
TIMEOUT_CYCLES, 255, max cycles dmem_req may stay high without dmem_ack before abort (1..65535)

Ports:
CLK  in  1  clock, all state updates on rising edge
RES  in  1  reset, synchronous, active-high
memRead  in  1  load request (level)
memWrite  in  1  store request (level)
funct3  in  3  width/sign code of the load/store instruction
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  memory read word, valid when dmem_ack=1
dmem_ack  in  1  transaction complete
busy  out  1  transaction in progress (REQ state)
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result, held until next load completes
err  out  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset, synchronous: all outputs 0, state IDLE, timeout counter 0. Applies mid-transaction too: dmem_req drops at that edge and no done is produced.
- States:
  - IDLE: no access in flight.
  - REQ: dmem_req=1, busy=1.
  - DONE: done=1 for one cycle.
  - HOLD: wait until memRead=memWrite=0.
- Accept rule: in IDLE with memRead|memWrite=1, sample funct3/addr/wdata into registers.
- Legality check:
  - memRead&memWrite both high is illegal.
  - Load funct3 must be 000/001/010/100/101. Store funct3 must be 000/001/010.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Any illegal case -> DONE with err=1 next cycle. dmem_req never asserts.
- Legal request -> REQ next cycle. dmem_req/we/addr/be/wdata are registered and stable for the whole REQ.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
  - Loads drive the same be pattern.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- REQ, dmem_ack=1 at an edge -> DONE. For loads, rdata <= extended lane of dmem_rdata:
  - Lane = dmem_rdata >> (addr[1:0]*8).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
- Timeout: counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES -> DONE with err=1, rdata unchanged, dmem_req deasserted.
- Ack and timeout on the same cycle: ack wins, err=0.
- dmem_ack outside REQ is ignored.
- DONE -> HOLD if memRead|memWrite still high, else IDLE. HOLD -> IDLE when both are low. No relaunch while held.
- Latency: zero-wait memory (ack in first REQ cycle) gives done 2 cycles after accept. Each wait cycle adds 1.
- Stores leave rdata unchanged.

Decomposition:
- define_constant.v gains:
  - funct3 encodings FN3_B/H/W/BU/HU.
  - State encodings MA_IDLE/MA_REQ/MA_DONE/MA_HOLD.
- One combinational sub-module, load_extend: inputs word, offset[1:0], funct3; output extended 32-bit value.

Test Plan:
- LW addr=0x100, ack same cycle as req, rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, done at accept+2, rdata=0xDEADBEEF, err=0.
- LB addr=0x103, dmem_rdata=0x80112233 -> be=1000, rdata=0xFFFFFF80. Repeat as LBU -> rdata=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, ack after 3 wait cycles -> dmem_we=1, be=1100, dmem_wdata=0xABCDABCD, busy high 4 cycles, done at accept+5.
- LW addr=0x101 -> no dmem_req, done=err=1 at accept+1. memRead held 4 more cycles -> exactly one done.
- TIMEOUT_CYCLES=4, never ack -> dmem_req high 4 cycles, then done=err=1, rdata unchanged.
- RES asserted during REQ wait -> at that edge dmem_req=0, busy=0, no done. New LW afterwards completes normally.
